// File: rtl/fp_convert_ctrl.sv
// fp_convert_ctrl: multi-cycle sequencer that converts a 12-bit two's-complement
// sample into sign / 3-bit exponent / 4-bit significand (value = (-1)^S * F * 2^E).
// Each sample goes through magnitude, leading-one encode and round stages.
// The result is held until the consumer accepts it.

// priority_encoder: index of the most significant set bit of i_vec.
module priority_encoder #(
    parameter int W  = 12,
    parameter int PW = $clog2(W)
) (
    input  logic [W-1:0]  i_vec,
    output logic [PW-1:0] o_pos,
    output logic          o_valid
);

    // Scan upward so that the highest set bit is the one left in o_pos
    always_comb begin
        o_pos   = '0;
        o_valid = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            if (i_vec[i]) begin
                o_pos   = PW'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

module fp_convert_ctrl #(
    parameter int ROUND_EN = 1,
    parameter int COUNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [11:0]        in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sign,
    output logic [2:0]         out_exp,
    output logic [3:0]         out_sig,
    output logic               out_sat,
    output logic [COUNT_W-1:0] done_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAG,
        ST_ENC,
        ST_RND,
        ST_DONE
    } state_t;

    state_t r_state;

    // Working registers for the sample in flight
    logic [11:0]        r_data;
    logic [11:0]        r_mag;
    logic               r_sign;
    logic               r_sat_pend;
    logic [2:0]         r_exp;
    logic [3:0]         r_sig;
    logic               r_rbit;

    // Registered result fields and accepted-result counter
    logic               r_out_valid;
    logic               r_out_sign;
    logic [2:0]         r_out_exp;
    logic [3:0]         r_out_sig;
    logic               r_out_sat;
    logic [COUNT_W-1:0] r_done_count;

    // Magnitude stage
    logic [11:0]        w_neg;

    // Encode stage
    logic [3:0]         w_pos;
    logic               w_lead;
    logic [2:0]         w_enc_exp;
    logic [2:0]         w_enc_exp_m1;
    logic [3:0]         w_enc_sig;
    logic               w_enc_rbit;

    // Round stage
    logic [4:0]         w_sig_inc;
    logic [3:0]         w_rnd_sig;
    logic [2:0]         w_rnd_exp;
    logic               w_rnd_sat;

    assign in_ready   = (r_state == ST_IDLE) & ~rst;
    assign out_valid  = r_out_valid;
    assign out_sign   = r_out_sign;
    assign out_exp    = r_out_exp;
    assign out_sig    = r_out_sig;
    assign out_sat    = r_out_sat;
    assign done_count = r_done_count;

    assign w_neg = ~r_data + 12'd1;

    priority_encoder #(
        .W  (12),
        .PW (4)
    ) u_penc (
        .i_vec   (r_mag),
        .o_pos   (w_pos),
        .o_valid (w_lead)
    );

    // Exponent aligns the leading one to the top of the 4-bit significand;
    // magnitudes below 16 keep exponent 0
    always_comb begin
        w_enc_exp = '0;
        if (w_lead && (w_pos > 4'd3)) begin
            w_enc_exp = 3'(w_pos - 4'd3);
        end
    end

    assign w_enc_sig    = 4'(r_mag >> w_enc_exp);
    assign w_enc_exp_m1 = w_enc_exp - 3'd1;
    assign w_enc_rbit   = (w_enc_exp != 3'd0) && r_mag[w_enc_exp_m1];

    assign w_sig_inc = {1'b0, r_sig} + 5'd1;

    // Round-half-up; a significand carry renormalises into the exponent,
    // and a carry out of the top exponent saturates instead
    always_comb begin
        w_rnd_sig = r_sig;
        w_rnd_exp = r_exp;
        w_rnd_sat = r_sat_pend;
        if ((ROUND_EN != 0) && r_rbit) begin
            if (!w_sig_inc[4]) begin
                w_rnd_sig = w_sig_inc[3:0];
            end else if (r_exp != 3'd7) begin
                w_rnd_sig = 4'd8;
                w_rnd_exp = r_exp + 3'd1;
            end else begin
                w_rnd_sig = 4'd15;
                w_rnd_sat = 1'b1;
            end
        end
    end

    // Conversion sequencer: stage registers, result registers and counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_data       <= '0;
            r_mag        <= '0;
            r_sign       <= 1'b0;
            r_sat_pend   <= 1'b0;
            r_exp        <= '0;
            r_sig        <= '0;
            r_rbit       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_sign   <= 1'b0;
            r_out_exp    <= '0;
            r_out_sig    <= '0;
            r_out_sat    <= 1'b0;
            r_done_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_data  <= in_data;
                        r_state <= ST_MAG;
                    end
                end
                ST_MAG: begin
                    r_sign <= r_data[11];
                    if (r_data == 12'h800) begin
                        // -2048 has no 12-bit positive counterpart
                        r_mag      <= 12'h7FF;
                        r_sat_pend <= 1'b1;
                    end else begin
                        r_mag      <= r_data[11] ? w_neg : r_data;
                        r_sat_pend <= 1'b0;
                    end
                    r_state <= ST_ENC;
                end
                ST_ENC: begin
                    r_exp   <= w_enc_exp;
                    r_sig   <= w_enc_sig;
                    r_rbit  <= w_enc_rbit;
                    r_state <= ST_RND;
                end
                ST_RND: begin
                    r_out_sign  <= r_sign;
                    r_out_exp   <= w_rnd_exp;
                    r_out_sig   <= w_rnd_sig;
                    r_out_sat   <= w_rnd_sat;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid  <= 1'b0;
                        r_done_count <= r_done_count + COUNT_W'(1);
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_convert_ctrl.sv
// Bench for fp_convert_ctrl: two instances (rounding on / truncating) run in
// lock-step and are compared against an arithmetic reference conversion.
module tb_fp_convert_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [11:0] in_data;

    logic        in_ready,   out_valid,   out_sign,   out_sat;
    logic [2:0]  out_exp;
    logic [3:0]  out_sig;
    logic [7:0]  done_count;

    logic        in_ready_t, out_valid_t, out_sign_t, out_sat_t;
    logic [2:0]  out_exp_t;
    logic [3:0]  out_sig_t;
    logic [7:0]  done_count_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_count = 0;
    int lat;
    int accept_cyc;

    logic        cap_v, cap_s, cap_sat, cap_v_t, cap_s_t, cap_sat_t;
    logic [2:0]  cap_e, cap_e_t;
    logic [3:0]  cap_f, cap_f_t;

    fp_convert_ctrl #(.ROUND_EN(1), .COUNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_sig(out_sig),
        .out_sat(out_sat), .done_count(done_count)
    );

    fp_convert_ctrl #(.ROUND_EN(0), .COUNT_W(8)) u_dut_t (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t),
        .in_data(in_data), .out_valid(out_valid_t), .out_ready(out_ready),
        .out_sign(out_sign_t), .out_exp(out_exp_t), .out_sig(out_sig_t),
        .out_sat(out_sat_t), .done_count(done_count_t)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Reference conversion from the numeric value of the sample
    function automatic void ref_conv(input logic [11:0] x, input bit rnd,
                                     output logic s, output logic [2:0] e,
                                     output logic [3:0] f, output logic sat);
        int v, m, ee, ff, rb;
        v   = x[11] ? int'(x) - 4096 : int'(x);
        s   = (v < 0);
        m   = (v < 0) ? -v : v;
        sat = 1'b0;
        if (m == 2048) begin
            m   = 2047;
            sat = 1'b1;
        end
        ee = 0;
        while ((m >> (ee + 4)) != 0) ee++;
        ff = (m >> ee) & 15;
        rb = (ee > 0) ? ((m >> (ee - 1)) & 1) : 0;
        if (rnd && rb == 1) begin
            ff++;
            if (ff == 16) begin
                if (ee < 7) begin
                    ff = 8;
                    ee++;
                end else begin
                    ff  = 15;
                    sat = 1'b1;
                end
            end
        end
        e = 3'(ee);
        f = 4'(ff);
    endfunction

    // Drive one sample through the handshake, capture the result, hold
    // out_ready low for 'hold' cycles, then accept it
    task automatic run_sample(input logic [11:0] d, input int hold);
        int n;
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        accept_cyc = cyc;
        in_valid = 1'b0;
        in_data  = 12'($urandom);
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        cap_v = out_valid;  cap_s = out_sign;  cap_e = out_exp;  cap_f = out_sig;  cap_sat = out_sat;
        cap_v_t = out_valid_t; cap_s_t = out_sign_t; cap_e_t = out_exp_t; cap_f_t = out_sig_t;
        cap_sat_t = out_sat_t;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (cap_v) exp_count++;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_sign, out_exp, out_sig, out_sat, done_count} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b s=%b e=%0d f=%0d sat=%b cnt=%0d required all 0",
                     out_valid, out_sign, out_exp, out_sig, out_sat, done_count);
        end
        checks++;
        if ({out_valid_t, out_sign_t, out_exp_t, out_sig_t, out_sat_t, done_count_t} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs_t got v=%b s=%b e=%0d f=%0d sat=%b cnt=%0d required all 0",
                     out_valid_t, out_sign_t, out_exp_t, out_sig_t, out_sat_t, done_count_t);
        end
        checks++;
        if (in_ready !== 1'b0 || in_ready_t !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready got %b/%b required 0/0", in_ready, in_ready_t);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || in_ready_t !== 1'b1) begin
            errors++;
            $display("FAIL release_in_ready got %b/%b required 1/1", in_ready, in_ready_t);
        end
        exp_count = 0;
    endtask

    task automatic test_directed();
        logic [11:0] vec [7];
        logic es, esat;
        logic [2:0] ee;
        logic [3:0] ef;
        vec = '{12'h000, 12'h1A6, 12'hFFF, 12'd46, 12'd125, 12'h800, 12'h7FF};
        for (int i = 0; i < 7; i++) begin
            run_sample(vec[i], 0);
            checks++;
            if (lat != 3) begin
                errors++;
                $display("FAIL dir_latency in=%h got %0d edges required 3", vec[i], lat);
            end
            ref_conv(vec[i], 1'b1, es, ee, ef, esat);
            checks++;
            if ({cap_v, cap_s, cap_e, cap_f, cap_sat} !== {1'b1, es, ee, ef, esat}) begin
                errors++;
                $display("FAIL dir_round in=%h got v=%b S=%b E=%0d F=%0d sat=%b required v=1 S=%b E=%0d F=%0d sat=%b",
                         vec[i], cap_v, cap_s, cap_e, cap_f, cap_sat, es, ee, ef, esat);
            end
            ref_conv(vec[i], 1'b0, es, ee, ef, esat);
            checks++;
            if ({cap_v_t, cap_s_t, cap_e_t, cap_f_t, cap_sat_t} !== {1'b1, es, ee, ef, esat}) begin
                errors++;
                $display("FAIL dir_trunc in=%h got v=%b S=%b E=%0d F=%0d sat=%b required v=1 S=%b E=%0d F=%0d sat=%b",
                         vec[i], cap_v_t, cap_s_t, cap_e_t, cap_f_t, cap_sat_t, es, ee, ef, esat);
            end
        end
        checks++;
        if (done_count !== 8'(exp_count) || done_count_t !== 8'(exp_count)) begin
            errors++;
            $display("FAIL dir_count got %0d/%0d required %0d", done_count, done_count_t, exp_count);
        end
    endtask

    task automatic test_random();
        logic [11:0] d;
        logic es, esat;
        logic [2:0] ee;
        logic [3:0] ef;
        for (int i = 0; i < 40; i++) begin
            d = 12'($urandom);
            run_sample(d, int'($urandom_range(0, 2)));
            ref_conv(d, 1'b1, es, ee, ef, esat);
            checks++;
            if ({cap_v, cap_s, cap_e, cap_f, cap_sat} !== {1'b1, es, ee, ef, esat}) begin
                errors++;
                $display("FAIL rand_round in=%h got v=%b S=%b E=%0d F=%0d sat=%b required v=1 S=%b E=%0d F=%0d sat=%b",
                         d, cap_v, cap_s, cap_e, cap_f, cap_sat, es, ee, ef, esat);
            end
            ref_conv(d, 1'b0, es, ee, ef, esat);
            checks++;
            if ({cap_v_t, cap_s_t, cap_e_t, cap_f_t, cap_sat_t} !== {1'b1, es, ee, ef, esat}) begin
                errors++;
                $display("FAIL rand_trunc in=%h got v=%b S=%b E=%0d F=%0d sat=%b required v=1 S=%b E=%0d F=%0d sat=%b",
                         d, cap_v_t, cap_s_t, cap_e_t, cap_f_t, cap_sat_t, es, ee, ef, esat);
            end
        end
        checks++;
        if (done_count !== 8'(exp_count)) begin
            errors++;
            $display("FAIL rand_count got %0d required %0d", done_count, exp_count);
        end
    endtask

    task automatic test_backpressure();
        logic es, esat;
        logic [2:0] ee;
        logic [3:0] ef;
        logic [11:0] first, second;
        int n;
        first  = 12'd300;
        second = 12'h555;
        in_data = first; in_valid = 1'b1;
        @(posedge clk); #1;
        // source keeps in_valid high with a different sample while busy
        in_data = second;
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        cap_s = out_sign; cap_e = out_exp; cap_f = out_sig; cap_sat = out_sat;
        ref_conv(first, 1'b1, es, ee, ef, esat);
        checks++;
        if ({out_valid, cap_s, cap_e, cap_f, cap_sat} !== {1'b1, es, ee, ef, esat}) begin
            errors++;
            $display("FAIL bp_first got v=%b S=%b E=%0d F=%0d sat=%b required v=1 S=%b E=%0d F=%0d sat=%b",
                     out_valid, cap_s, cap_e, cap_f, cap_sat, es, ee, ef, esat);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_valid, out_sign, out_exp, out_sig, out_sat, in_ready} !== {1'b1, cap_s, cap_e, cap_f, cap_sat, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d got v=%b S=%b E=%0d F=%0d sat=%b rdy=%b required v=1 S=%b E=%0d F=%0d sat=%b rdy=0",
                         i, out_valid, out_sign, out_exp, out_sig, out_sat, in_ready, cap_s, cap_e, cap_f, cap_sat);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_count++;
        checks++;
        if ({out_valid, in_ready} !== 2'b01 || done_count !== 8'(exp_count)) begin
            errors++;
            $display("FAIL bp_accept got v=%b rdy=%b cnt=%0d required v=0 rdy=1 cnt=%0d",
                     out_valid, in_ready, done_count, exp_count);
        end
        // held in_valid is taken on the next edge, not the acceptance edge
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL bp_second_latency got %0d edges required 4", n);
        end
        ref_conv(second, 1'b1, es, ee, ef, esat);
        checks++;
        if ({out_valid, out_sign, out_exp, out_sig, out_sat} !== {1'b1, es, ee, ef, esat}) begin
            errors++;
            $display("FAIL bp_second got v=%b S=%b E=%0d F=%0d sat=%b required v=1 S=%b E=%0d F=%0d sat=%b",
                     out_valid, out_sign, out_exp, out_sig, out_sat, es, ee, ef, esat);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_count++;
    endtask

    task automatic test_back_to_back();
        logic [11:0] vec [4];
        logic es, esat;
        logic [2:0] ee;
        logic [3:0] ef;
        int prev;
        vec = '{12'd1000, 12'hC00, 12'd17, 12'h9A3};
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            run_sample(vec[i], 0);
            if (prev >= 0) begin
                checks++;
                if (accept_cyc - prev != 5) begin
                    errors++;
                    $display("FAIL b2b_spacing got %0d cycles required 5", accept_cyc - prev);
                end
            end
            prev = accept_cyc;
            ref_conv(vec[i], 1'b1, es, ee, ef, esat);
            checks++;
            if ({cap_v, cap_s, cap_e, cap_f, cap_sat} !== {1'b1, es, ee, ef, esat}) begin
                errors++;
                $display("FAIL b2b_result in=%h got v=%b S=%b E=%0d F=%0d sat=%b required v=1 S=%b E=%0d F=%0d sat=%b",
                         vec[i], cap_v, cap_s, cap_e, cap_f, cap_sat, es, ee, ef, esat);
            end
        end
        checks++;
        if (done_count !== 8'(exp_count)) begin
            errors++;
            $display("FAIL b2b_count got %0d required %0d", done_count, exp_count);
        end
    endtask

    task automatic test_reset_mid();
        logic es, esat;
        logic [2:0] ee;
        logic [3:0] ef;
        int stray;
        in_data = 12'd777; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_sign, out_exp, out_sig, out_sat, done_count, in_ready} !== 18'd0) begin
            errors++;
            $display("FAIL midrst_outputs got v=%b s=%b e=%0d f=%0d sat=%b cnt=%0d rdy=%b required all 0",
                     out_valid, out_sign, out_exp, out_sig, out_sat, done_count, in_ready);
        end
        exp_count = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_in_ready got %b required 1", in_ready);
        end
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL midrst_stray_valid got %0d cycles high required 0", stray);
        end
        run_sample(12'hE21, 0);
        ref_conv(12'hE21, 1'b1, es, ee, ef, esat);
        checks++;
        if ({cap_v, cap_s, cap_e, cap_f, cap_sat} !== {1'b1, es, ee, ef, esat} || done_count !== 8'd1) begin
            errors++;
            $display("FAIL midrst_convert got v=%b S=%b E=%0d F=%0d sat=%b cnt=%0d required v=1 S=%b E=%0d F=%0d sat=%b cnt=1",
                     cap_v, cap_s, cap_e, cap_f, cap_sat, done_count, es, ee, ef, esat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
